// File: rtl/ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module   : ifu_fetch
// Purpose  : Instruction fetch stage ahead of decode. Keeps the fetch PC,
//            issues in-order requests to instruction memory under a credit
//            limit, buffers returned words in a small FIFO and hands
//            {inst, inst_pc} to decode over valid/ready. Redirects load a new
//            PC and flush wrong-path words. Halt (ebreak) stops issue.
// Ports    : clk, rst_n (async, active-low)
//            redirect_valid/redirect_pc : taken branch/jump target
//            halt                       : sticky stop of request issue
//            imem_req_*                 : request channel (valid/ready/addr)
//            imem_rsp_*                 : in-order response words
//            inst_valid/inst_ready/inst/inst_pc : decode handshake
//            fetch_misalign             : misaligned redirect flag
// Macro    : IFU_MISALIGN_TRAP_EN - misaligned redirect sets fetch_misalign
//            and halts; otherwise redirect_pc[1:0] is cleared on load.
// Revision : 1.0 - initial release
// ============================================================================
module ifu_fetch #(
  parameter int                    ADDR_WIDTH = 64,
  parameter int                    INST_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 64'h8000_0000,
  parameter int                    FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  halt,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [INST_WIDTH-1:0] imem_rsp_data,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [INST_WIDTH-1:0] inst,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  output logic                  fetch_misalign
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = $clog2(FIFO_DEPTH);

  logic                  run_q;
  logic                  halted_q, halted_d;
  logic                  misalign_q, misalign_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]         out_q, out_d;
  logic [CW-1:0]         drop_q, drop_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         pcq_rd_q, pcq_wr_q;

  logic [INST_WIDTH-1:0] mem_data [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] mem_pc   [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] pcq      [FIFO_DEPTH];

  logic                  w_accept, w_redir, w_drop, w_push, w_pop, w_misal;
  logic [CW:0]           w_occ;
  logic [ADDR_WIDTH-1:0] w_target;
  logic                  w_unused_bits;

  // Credits cover both buffered words and words still in flight, so the
  // FIFO can never overflow however late responses arrive.
  assign w_occ          = {1'b0, cnt_q} + {1'b0, out_q};
  assign imem_req_valid = run_q && !halted_q && (w_occ < (CW+1)'(FIFO_DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign w_accept       = imem_req_valid && imem_req_ready;
  assign w_misal        = (redirect_pc[1:0] != 2'b00);
  assign w_unused_bits  = w_misal;

  // Once halted a redirect only moves fetch_pc; nothing is flushed, so the
  // words already in flight still drain to decode.
  assign w_redir = redirect_valid && !halted_q;
  assign w_drop  = imem_rsp_valid && ((drop_q != '0) || w_redir);
  assign w_push  = imem_rsp_valid && !w_drop;
  assign w_pop   = inst_valid && inst_ready;

  assign inst_valid     = (cnt_q != '0);
  assign inst           = inst_valid ? mem_data[rd_ptr_q] : '0;
  assign inst_pc        = inst_valid ? mem_pc[rd_ptr_q]   : '0;
  assign fetch_misalign = misalign_q;

`ifdef IFU_MISALIGN_TRAP_EN
  assign w_target = redirect_pc;
`else
  assign w_target = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
`endif

  always_comb begin
    halted_d   = halted_q | halt;
    misalign_d = misalign_q;
`ifdef IFU_MISALIGN_TRAP_EN
    if (redirect_valid && w_misal) begin
      halted_d   = 1'b1;
      misalign_d = 1'b1;
    end
`endif
    fetch_pc_d = fetch_pc_q;
    if (redirect_valid)
      fetch_pc_d = w_target;
    else if (w_accept)
      fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);

    out_d = out_q + CW'(w_accept) - CW'(imem_rsp_valid);

    // On redirect every word still in flight (including one accepted this
    // very cycle) is stale; a response landing now is already excluded.
    drop_d = drop_q;
    if (w_redir)
      drop_d = out_d;
    else if (imem_rsp_valid && (drop_q != '0))
      drop_d = drop_q - CW'(1);

    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (w_redir) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (w_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (w_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      cnt_d = cnt_q + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q      <= 1'b0;
      halted_q   <= 1'b0;
      misalign_q <= 1'b0;
      fetch_pc_q <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
      cnt_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      pcq_rd_q   <= '0;
      pcq_wr_q   <= '0;
    end else begin
      run_q      <= 1'b1;
      halted_q   <= halted_d;
      misalign_q <= misalign_d;
      fetch_pc_q <= fetch_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      cnt_q      <= cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      // The PC queue mirrors memory order, so it advances even for words
      // that end up dropped.
      if (w_accept)       pcq_wr_q <= pcq_wr_q + PW'(1);
      if (imem_rsp_valid) pcq_rd_q <= pcq_rd_q + PW'(1);
    end
  end

  // Storage only; validity is tracked by the pointers and counts above.
  always_ff @(posedge clk) begin
    if (w_accept)
      pcq[pcq_wr_q] <= fetch_pc_q;
    if (w_push) begin
      mem_data[wr_ptr_q] <= imem_rsp_data;
      mem_pc[wr_ptr_q]   <= pcq[pcq_rd_q];
    end
  end

endmodule
`default_nettype wire
